fetch_sequencer: RTL and testbench

//  Fetch-stage controller that sequences the PC register. Generates next-PC
//  (npc) fed back into the PC register. Runs the req/ack instruction-memory

---
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch-stage controller. Drives the next-PC that the external PC register
//   loads every clock, runs a single-outstanding req/ack handshake towards
//   instruction memory, and buffers returned words in a 2-entry FIFO that
//   feeds IF/ID. Redirect sources resolve as exc > br_taken > jmp.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   pc / npc          current PC in, next PC out (RESET_VECTOR while in reset)
//   imem_req/addr     fetch request and address (address is always pc)
//   imem_ack/rdata    memory response, may land in the same cycle as req
//   if_valid/instr/pc FIFO head towards decode
//   id_ready          decode pops the head when if_valid && id_ready
//   exc, br_*, jmp_*  redirect requests
//   flush             combinational, high in every redirect cycle
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        flush
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t      r_state;
    logic        r_pend;
    logic [31:0] r_pend_tgt;
    logic [1:0]  r_count;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic        w_wait;
    logic [1:0]  w_count_nxt;
    logic [1:0]  w_widx;
    logic [31:0] w_npc;

    assign w_redirect = exc | br_taken | jmp;
    assign w_target   = exc ? EXC_VECTOR : (br_taken ? br_target : jmp_target);

    // Acks are only meaningful while a request is live; a stale ack seen in
    // S_IDLE after reset belongs to an abandoned request.
    assign w_ack  = (r_state == S_FETCH) && imem_ack;
    // Redirect while the request is still waiting: it cannot be cancelled,
    // so the target is parked until the ack returns.
    assign w_wait = (r_state == S_FETCH) && !imem_ack;
    assign w_push = w_ack && !w_redirect && !r_pend;
    assign w_pop  = (r_count != 2'd0) && id_ready && !w_redirect;

    assign w_count_nxt = w_redirect ? 2'd0
                       : r_count + {1'b0, w_push} - {1'b0, w_pop};
    // Slot for the pushed word once the pop shift has been applied.
    assign w_widx = r_count - {1'b0, w_pop};

    always_comb begin
        w_npc = pc;
        if (!rst_n)
            w_npc = RESET_VECTOR;
        else if (w_redirect) begin
            if (!w_wait)
                w_npc = w_target;
        end
        else if (w_ack && r_pend)
            w_npc = r_pend_tgt;
        else if (w_push)
            w_npc = pc + 32'd4;
    end

    assign npc       = w_npc;
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = pc;
    assign if_valid  = (r_count != 2'd0);
    assign if_instr  = if_valid ? r_q_instr[0] : 32'd0;
    assign if_pc     = if_valid ? r_q_pc[0]    : 32'd0;
    assign flush     = rst_n & w_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: begin
                    if (!w_redirect && w_ack && (w_count_nxt == 2'd2))
                        r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_redirect || (w_count_nxt <= 2'd1))
                        r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_redirect) begin
                r_pend <= w_wait;
                if (w_wait)
                    r_pend_tgt <= w_target;
            end else if (w_ack) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Head always lives in slot 0; a pop shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 2'd0;
            r_q_pc[0]    <= 32'd0;
            r_q_pc[1]    <= 32'd0;
            r_q_instr[0] <= 32'd0;
            r_q_instr[1] <= 32'd0;
        end else begin
            r_count <= w_count_nxt;
            if (!w_redirect) begin
                if (w_pop) begin
                    r_q_pc[0]    <= r_q_pc[1];
                    r_q_instr[0] <= r_q_instr[1];
                end
                if (w_push) begin
                    r_q_pc[w_widx[0]]    <= pc;
                    r_q_instr[w_widx[0]] <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register and a credit-limited
// instruction memory (rdata = addr + 0x1000_0000), pushes hand-computed
// expected {pc, instr} pairs into a scoreboard, and a monitor pops and
// compares on every decode handshake.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        exc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        flush;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    logic [63:0] sb[$];

    // memory model
    int   ack_limit  = 0;
    int   acks_given = 0;
    int   lat        = 0;
    int   wcnt       = 0;
    logic force_ack  = 1'b0;
    logic w_mack;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .exc(exc), .br_taken(br_taken),
        .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .flush(flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register
    always @(posedge clk) pc <= npc;

    assign w_mack     = imem_req && (acks_given < ack_limit) && (wcnt >= lat);
    assign imem_ack   = force_ack | w_mack;
    assign imem_rdata = force_ack ? 32'hDEAD_BEEF : imem_addr + 32'h1000_0000;

    always @(posedge clk) begin
        if (w_mack) acks_given <= acks_given + 1;
        if (imem_req && !w_mack && (acks_given < ack_limit)) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] a);
        sb.push_back({a, a + 32'h1000_0000});
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 10; i++) begin
            if (imem_ack) break;
            @(negedge clk); #1;
        end
        chk("ack_seen", {31'd0, imem_ack}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        #2;
        if (rst_n && if_valid && id_ready && !flush) begin
            n_pop++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("if_pc", if_pc, e[63:32]);
                chk("if_instr", if_instr, e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_ready = 1'b1; exc = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        br_target = 32'd0; jmp_target = 32'd0;

        // 1: reset values, then one word per cycle
        repeat (2) @(negedge clk);
        #1;
        chk("rst_npc", npc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) expect_word(32'(i * 4));
        ack_limit = 5;
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("t1_throughput", n_pop, 32'd5);
        drain();

        // 2: back-pressure fills the queue, then FIFO order on release
        @(negedge clk);
        id_ready = 1'b0;
        ack_limit += 3;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t2_hold_npc", npc, pc);
        chk("t2_hold_pc", pc, 32'h1C);
        chk("t2_head_pc", if_pc, 32'h14);
        chk("t2_head_instr", if_instr, 32'h1000_0014);
        expect_word(32'h14); expect_word(32'h18); expect_word(32'h1C);
        @(negedge clk);
        id_ready = 1'b1;
        drain();

        // 3: branch while ack outstanding (3-cycle latency), queued word dropped
        @(negedge clk);
        id_ready = 1'b0;
        ack_limit += 1;
        repeat (2) @(negedge clk);
        lat = 3;
        ack_limit += 1;
        br_taken = 1'b1; br_target = 32'h40;
        #1;
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_npc_hold", npc, 32'h24);
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        chk("t3_flush_once", {31'd0, flush}, 32'd0);
        chk("t3_q_cleared", {31'd0, if_valid}, 32'd0);
        wait_ack();
        chk("t3_old_addr", imem_addr, 32'h24);
        chk("t3_npc_target", npc, 32'h40);
        @(negedge clk); #1;
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h40);
        chk("t3_dropped", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        expect_word(32'h40); expect_word(32'h44);
        ack_limit += 2;
        id_ready = 1'b1;
        drain();

        // 4a: all three redirects together, ack same cycle
        @(negedge clk);
        lat = 0;
        ack_limit += 1;
        exc = 1'b1; br_taken = 1'b1; jmp = 1'b1;
        br_target = 32'h300; jmp_target = 32'h400;
        #1;
        chk("t4_flush", {31'd0, flush}, 32'd1);
        chk("t4_npc_exc", npc, 32'h8000_0180);
        @(negedge clk);
        exc = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        #1;
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr_exc", imem_addr, 32'h8000_0180);
        chk("t4_dropped", {31'd0, if_valid}, 32'd0);

        // 4b: jmp then br two cycles later, both while pending
        @(negedge clk);
        jmp = 1'b1; jmp_target = 32'h100;
        #1;
        chk("t4b_jmp_flush", {31'd0, flush}, 32'd1);
        chk("t4b_npc_hold", npc, 32'h8000_0180);
        @(negedge clk);
        jmp = 1'b0;
        #1;
        chk("t4b_gap_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h200;
        #1;
        chk("t4b_br_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        br_taken = 1'b0;
        ack_limit += 1;
        #1;
        chk("t4b_ack", {31'd0, imem_ack}, 32'd1);
        chk("t4b_npc_pend", npc, 32'h200);
        chk("t4b_no_reflush", {31'd0, flush}, 32'd0);
        @(negedge clk); #1;
        chk("t4b_addr", imem_addr, 32'h200);
        @(negedge clk);
        expect_word(32'h200); expect_word(32'h204);
        ack_limit += 2;
        drain();

        // 5a: PC wrap
        @(negedge clk);
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        ack_limit += 1;
        #1;
        chk("t5_npc_jmp", npc, 32'hFFFF_FFFC);
        @(negedge clk);
        jmp = 1'b0;
        sb.push_back({32'hFFFF_FFFC, 32'h0FFF_FFFC});
        expect_word(32'h0);
        ack_limit += 2;
        #1;
        chk("t5_wrap_npc", npc, 32'h0);
        drain();

        // 5b: reset mid-wait, stale ack in S_IDLE ignored
        @(negedge clk);
        lat = 3;
        ack_limit += 1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_npc", npc, 32'h0);
        chk("t5_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t5_rst_valid", {31'd0, if_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        #1;
        chk("t5_idle_npc", npc, 32'h0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        lat = 0;
        expect_word(32'h0);
        #1;
        chk("t5_first_req", {31'd0, imem_req}, 32'd1);
        chk("t5_first_addr", imem_addr, 32'h0);
        drain();

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
